// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus: decoded source/destination info in, stall/bubble/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 16;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr;
    logic              id_load;
    logic              br_taken;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr, id_load, br_taken,
        input  stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr, id_load, br_taken,
        output stall, bubble, flush, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard detection and operand-forwarding select for an in-order pipeline.
// Tracks in-flight writers after ID in a shift register; decisions are same-cycle.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned STAGES = 3,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned FWD_W = 2;
    localparam logic [FWD_W-1:0] SRC_RF    = FWD_W'(0);
    localparam logic [FWD_W-1:0] SRC_EXMEM = FWD_W'(1);
    localparam logic [FWD_W-1:0] SRC_MEMWB = FWD_W'(2);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] rd;
    } slot_t;

    slot_t            slot_q [STAGES];
    slot_t            slot_in;
    logic             raw_any;
    logic             raw_hz;
    logic             stall_c;
    logic             bubble_c;
    logic [FWD_W-1:0] fwd_a_c;
    logic [FWD_W-1:0] fwd_b_c;
    logic [CNT_W-1:0] stall_cnt_q;

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic src_match(input logic used, input logic [REG_AW-1:0] src,
                                       input slot_t e);
        return used && (src != '0) && e.valid && e.wr && (e.rd == src);
    endfunction

    // Hazard and forward-select decode against the in-flight slots
    always_comb begin
        raw_any = 1'b0;
        fwd_a_c = SRC_RF;
        fwd_b_c = SRC_RF;
        if (FWD_EN) begin
            raw_any = slot_q[0].load &&
                      (src_match(bus.id_rs1_used, bus.id_rs1, slot_q[0]) ||
                       src_match(bus.id_rs2_used, bus.id_rs2, slot_q[0]));
            if (src_match(bus.id_rs1_used, bus.id_rs1, slot_q[0]))
                fwd_a_c = SRC_EXMEM;
            else if (src_match(bus.id_rs1_used, bus.id_rs1, slot_q[1]))
                fwd_a_c = SRC_MEMWB;
            if (src_match(bus.id_rs2_used, bus.id_rs2, slot_q[0]))
                fwd_b_c = SRC_EXMEM;
            else if (src_match(bus.id_rs2_used, bus.id_rs2, slot_q[1]))
                fwd_b_c = SRC_MEMWB;
        end else begin
            // last slot writes the register file before ID reads it
            for (int unsigned i = 0; i < STAGES - 1; i++) begin
                if (src_match(bus.id_rs1_used, bus.id_rs1, slot_q[i]) ||
                    src_match(bus.id_rs2_used, bus.id_rs2, slot_q[i]))
                    raw_any = 1'b1;
            end
        end
    end

    // Pipeline control; a taken branch overrides the stall and squashes ID
    always_comb begin
        raw_hz   = raw_any && bus.id_valid;
        stall_c  = raw_hz && !bus.br_taken;
        bubble_c = raw_hz || bus.br_taken || !bus.id_valid;
        slot_in  = '0;
        if (!bubble_c) begin
            slot_in.valid = bus.id_valid;
            slot_in.wr    = bus.id_wr;
            slot_in.load  = bus.id_load;
            slot_in.rd    = bus.id_rd;
        end
    end

    // In-flight tracker and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++)
                slot_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q[0] <= slot_in;
            for (int unsigned i = 1; i < STAGES; i++)
                slot_q[i] <= slot_q[i-1];
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall     = stall_c;
    assign bus.bubble    = bubble_c;
    assign bus.flush     = bus.br_taken;
    assign bus.fwd_a     = fwd_a_c;
    assign bus.fwd_b     = fwd_b_c;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: forwarding DUT (STAGES=3), stall-only DUT (STAGES=3) and a deep
// stall-only DUT (STAGES=8) used to drive the stall counter into saturation.
module tb_pipe_hazard_ctrl;
    localparam int unsigned REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_rs1_used, id_rs2_used, id_wr, id_load, br_taken;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    int unsigned       total = 0;
    int unsigned       bad = 0;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) f_if ();
    pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) s_if ();
    pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) g_if ();

    assign f_if.id_valid = id_valid, f_if.id_rs1 = id_rs1, f_if.id_rs2 = id_rs2,
           f_if.id_rs1_used = id_rs1_used, f_if.id_rs2_used = id_rs2_used,
           f_if.id_rd = id_rd, f_if.id_wr = id_wr, f_if.id_load = id_load,
           f_if.br_taken = br_taken;
    assign s_if.id_valid = id_valid, s_if.id_rs1 = id_rs1, s_if.id_rs2 = id_rs2,
           s_if.id_rs1_used = id_rs1_used, s_if.id_rs2_used = id_rs2_used,
           s_if.id_rd = id_rd, s_if.id_wr = id_wr, s_if.id_load = id_load,
           s_if.br_taken = br_taken;
    assign g_if.id_valid = id_valid, g_if.id_rs1 = id_rs1, g_if.id_rs2 = id_rs2,
           g_if.id_rs1_used = id_rs1_used, g_if.id_rs2_used = id_rs2_used,
           g_if.id_rd = id_rd, g_if.id_wr = id_wr, g_if.id_load = id_load,
           g_if.br_taken = br_taken;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .STAGES(3), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .bus(f_if.slave));
    pipe_hazard_ctrl #(.REG_AW(REG_AW), .STAGES(3), .FWD_EN(1'b0)) u_stl (
        .clk(clk), .rst(rst), .bus(s_if.slave));
    pipe_hazard_ctrl #(.REG_AW(REG_AW), .STAGES(8), .FWD_EN(1'b0)) u_sat (
        .clk(clk), .rst(rst), .bus(g_if.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [REG_AW-1:0] rs1, input logic u1,
                         input logic [REG_AW-1:0] rs2, input logic u2,
                         input logic [REG_AW-1:0] rd, input logic wr, input logic ld,
                         input logic br);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wr = wr; id_load = ld; br_taken = br;
        #1;
    endtask

    task automatic do_reset();
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned cyc;
        bit          mid_done;

        // Post-reset: empty slots give no hazard and no forwarding
        do_reset();
        issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_f_stall", 32'(f_if.stall), 32'd0);
        check("rst_f_fwd_a", 32'(f_if.fwd_a), 32'd0);
        check("rst_f_fwd_b", 32'(f_if.fwd_b), 32'd0);
        check("rst_s_stall", 32'(s_if.stall), 32'd0);
        check("rst_f_bubble", 32'(f_if.bubble), 32'd0);
        check("rst_cnt", 32'(f_if.stall_cnt), 32'd0);

        // ALU producer then back-to-back consumers: EX/MEM then MEM/WB forwarding
        do_reset();
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        check("alu_w_stall", 32'(f_if.stall), 32'd0);
        tick();
        issue(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("alu_r1_stall", 32'(f_if.stall), 32'd0);
        check("alu_r1_fwd_a", 32'(f_if.fwd_a), 32'd1);
        check("alu_r1_fwd_b", 32'(f_if.fwd_b), 32'd0);
        check("alu_s_stall", 32'(s_if.stall), 32'd1);
        tick();
        issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("alu_r2_fwd_a", 32'(f_if.fwd_a), 32'd2);
        check("alu_r2_stall", 32'(f_if.stall), 32'd0);

        // Youngest producer wins when two in-flight writers target the same register
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("young_fwd_b", 32'(f_if.fwd_b), 32'd1);

        // Load-use: one stall/bubble, then MEM/WB forward
        do_reset();
        issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        check("lu_stall", 32'(f_if.stall), 32'd1);
        check("lu_bubble", 32'(f_if.bubble), 32'd1);
        tick();
        check("lu_stall2", 32'(f_if.stall), 32'd0);
        check("lu_bubble2", 32'(f_if.bubble), 32'd0);
        check("lu_fwd_b", 32'(f_if.fwd_b), 32'd2);
        check("lu_cnt", 32'(f_if.stall_cnt), 32'd1);
        tick();
        check("lu_cnt_hold", 32'(f_if.stall_cnt), 32'd1);

        // Stall-only: writer then reader stalls two cycles, no forwarding
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("so_stall1", 32'(s_if.stall), 32'd1);
        tick();
        check("so_stall2", 32'(s_if.stall), 32'd1);
        tick();
        check("so_stall3", 32'(s_if.stall), 32'd0);
        check("so_fwd_a", 32'(s_if.fwd_a), 32'd0);
        check("so_bubble", 32'(s_if.bubble), 32'd0);
        check("so_cnt", 32'(s_if.stall_cnt), 32'd2);

        // Taken branch on a load-use cycle: flush wins, no stall counted
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        check("br_flush", 32'(f_if.flush), 32'd1);
        check("br_stall", 32'(f_if.stall), 32'd0);
        check("br_bubble", 32'(f_if.bubble), 32'd1);
        tick();
        check("br_cnt", 32'(f_if.stall_cnt), 32'd0);
        issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        check("br_flush_off", 32'(f_if.flush), 32'd0);
        check("br_after_fwd_a", 32'(f_if.fwd_a), 32'd2);

        // r0 never matches; an unused source never matches
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("r0_f_stall", 32'(f_if.stall), 32'd0);
        check("r0_f_fwd_a", 32'(f_if.fwd_a), 32'd0);
        check("r0_f_fwd_b", 32'(f_if.fwd_b), 32'd0);
        check("r0_s_stall", 32'(s_if.stall), 32'd0);
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd9, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("unused_f_fwd_a", 32'(f_if.fwd_a), 32'd0);
        check("unused_f_stall", 32'(f_if.stall), 32'd0);
        check("unused_s_stall", 32'(s_if.stall), 32'd0);

        // Invalid ID: no stall even with a matching producer
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("inv_s_stall", 32'(s_if.stall), 32'd0);
        check("inv_s_bubble", 32'(s_if.bubble), 32'd1);

        // Reset mid-stall cancels the pending hazard
        do_reset();
        issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("mid_stall_on", 32'(s_if.stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_stall_off", 32'(s_if.stall), 32'd0);
        check("mid_cnt", 32'(s_if.stall_cnt), 32'd0);

        // Saturation: self-dependent writer keeps re-stalling the deep stall-only DUT
        do_reset();
        issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        n = 0;
        cyc = 0;
        mid_done = 1'b0;
        while (n < 65540 && cyc < 80000) begin
            if (g_if.stall) n++;
            tick();
            cyc++;
            if (n == 100 && !mid_done) begin
                mid_done = 1'b1;
                check("sat_cnt_100", 32'(g_if.stall_cnt), 32'd100);
            end
        end
        check("sat_reached", 32'(n), 32'd65540);
        check("sat_cnt", 32'(g_if.stall_cnt), 32'h0000_FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_cnt", 32'(g_if.stall_cnt), 32'd0);
        check("sat_rst_stall", 32'(g_if.stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
